comp_div: RTL

- Sequential signed complex divider: computes (a_r + j·a_i) / (b_r + j·b_i) and returns a fixed-point result with FRAC fractional bits.
- It is the inverse companion of the time-multiplexed complex multiplier in the same datapath and shares its operand format (signed 8-bit real and imaginary parts).
- It reuses a single 8x8 signed multiplier over six cycles, then runs a bit-serial restoring divider, first for the real part and then for the imaginary part.

---
 rtl/comp_div.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/comp_div.sv
// Sequential signed complex divider: (a_r + j*a_i) / (b_r + j*b_i) in Q(8.FRAC).
// One shared 8x8 multiplier over six cycles, then restoring division for the real and imaginary parts.
module comp_div #(
    parameter int FRAC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [7:0]      a_r,
    input  logic signed [7:0]      a_i,
    input  logic signed [7:0]      b_r,
    input  logic signed [7:0]      b_i,
    input  logic                   i_en,
    output logic                   busy,
    output logic signed [8+FRAC:0] o_r,
    output logic signed [8+FRAC:0] o_i,
    output logic                   o_valid,
    output logic                   div_zero
);
    localparam int OW = 9 + FRAC;
    localparam int NW = 17 + FRAC;
    localparam int RW = 17;
    localparam int CW = $clog2(OW);

    // state | meaning
    // IDLE  | waiting for i_en, operands captured on accept
    // MUL   | six products through the shared multiplier (step 0..5)
    // DIV_R | OW-edge restoring division of |num_r|*2^FRAC by den
    // DIV_I | OW-edge restoring division of |num_i|*2^FRAC by den
    // DONE  | one cycle with o_valid high
    typedef enum logic [2:0] {IDLE, MUL, DIV_R, DIV_I, DONE} state_t;

    state_t                 state_q;
    logic [2:0]             step_q;
    logic signed [7:0]      ar_q, ai_q, br_q, bi_q;
    logic [16:0]            den_q;
    logic signed [16:0]     num_r_q, num_i_q;
    logic [RW-1:0]          rem_q;
    logic [OW-1:0]          sh_q;
    logic                   neg_q;
    logic [CW-1:0]          cnt_q;
    logic signed [OW-1:0]   qr_q;
    logic                   busy_q, o_valid_q, div_zero_q;
    logic signed [OW-1:0]   o_r_q, o_i_q;

    logic signed [7:0]      mul_x, mul_y;
    logic signed [15:0]     prod;
    logic signed [16:0]     prod_x;
    logic signed [16:0]     ld_num;
    logic [16:0]            ld_mag;
    logic [NW-1:0]          ld_n;
    logic [RW-1:0]          ld_rem;
    logic [OW-1:0]          ld_sh;
    logic [RW-1:0]          trial, rem_d;
    logic                   q_bit;
    logic [OW-1:0]          q_full;
    logic signed [OW-1:0]   q_signed;

    always_comb begin
        mul_x = br_q;
        mul_y = br_q;
        case (step_q)
            3'd1: begin mul_x = bi_q; mul_y = bi_q; end
            3'd2: begin mul_x = ar_q; mul_y = br_q; end
            3'd3: begin mul_x = ai_q; mul_y = bi_q; end
            3'd4: begin mul_x = ai_q; mul_y = br_q; end
            3'd5: begin mul_x = ar_q; mul_y = bi_q; end
            default: ;
        endcase
        prod   = mul_x * mul_y;
        prod_x = {prod[15], prod};
    end

    // Dividend preload: the top bits of |num|*2^FRAC seed the remainder, since the
    // quotient always fits in OW bits those bits are already smaller than den.
    always_comb begin
        ld_num = (state_q == MUL) ? num_r_q : num_i_q;
        ld_mag = ld_num[16] ? 17'(-ld_num) : 17'(ld_num);
        ld_n   = {ld_mag, {FRAC{1'b0}}};
        ld_rem = RW'(ld_n[NW-1:OW]);
        ld_sh  = ld_n[OW-1:0];
    end

    always_comb begin
        trial    = {rem_q[RW-2:0], sh_q[OW-1]};
        q_bit    = (trial >= den_q);
        rem_d    = q_bit ? (trial - den_q) : trial;
        q_full   = {sh_q[OW-2:0], q_bit};
        q_signed = neg_q ? $signed(-q_full) : $signed(q_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            den_q      <= '0;
            num_r_q    <= '0;
            num_i_q    <= '0;
            rem_q      <= '0;
            sh_q       <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            qr_q       <= '0;
            busy_q     <= 1'b0;
            o_valid_q  <= 1'b0;
            div_zero_q <= 1'b0;
            o_r_q      <= '0;
            o_i_q      <= '0;
        end else begin
            o_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_en) begin
                        ar_q    <= a_r;
                        ai_q    <= a_i;
                        br_q    <= b_r;
                        bi_q    <= b_i;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    step_q <= step_q + 3'd1;
                    case (step_q)
                        3'd0: den_q   <= 17'(prod_x);
                        3'd1: den_q   <= den_q + 17'(prod_x);
                        3'd2: num_r_q <= prod_x;
                        3'd3: num_r_q <= num_r_q + prod_x;
                        3'd4: num_i_q <= prod_x;
                        default: begin
                            num_i_q <= num_i_q - prod_x;
                            step_q  <= '0;
                            if (den_q == 17'd0) begin
                                o_r_q      <= '0;
                                o_i_q      <= '0;
                                div_zero_q <= 1'b1;
                                o_valid_q  <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                rem_q   <= ld_rem;
                                sh_q    <= ld_sh;
                                neg_q   <= num_r_q[16];
                                cnt_q   <= CW'(OW - 1);
                                state_q <= DIV_R;
                            end
                        end
                    endcase
                end
                DIV_R: begin
                    rem_q <= rem_d;
                    sh_q  <= q_full;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        qr_q    <= q_signed;
                        rem_q   <= ld_rem;
                        sh_q    <= ld_sh;
                        neg_q   <= num_i_q[16];
                        cnt_q   <= CW'(OW - 1);
                        state_q <= DIV_I;
                    end
                end
                DIV_I: begin
                    rem_q <= rem_d;
                    sh_q  <= q_full;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        o_r_q      <= qr_q;
                        o_i_q      <= q_signed;
                        div_zero_q <= 1'b0;
                        o_valid_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign o_valid  = o_valid_q;
    assign div_zero = div_zero_q;
    assign o_r      = o_r_q;
    assign o_i      = o_i_q;
endmodule
